// File: rtl/score_tally_if.sv
// score_tally_if: keyboard/lane inputs and score/status outputs of the
// score_tally stage, grouped as one bundle.
//   keycode   : primary keyboard keycode (0x2C start, 0x01 return)
//   lane_hit  : per-lane dropper score flags (level, held high after a hit)
//   score     : binary score, saturating at 9999
//   score_bcd : 4-digit BCD of score, digit 3 in [15:12]
//   bcd_busy  : BCD conversion in progress
//   hit_count : total hits, saturating at 255
//   playing   : game in PLAYING
//   game_over : game in DONE
// master drives keycode/lane_hit; slave (score_tally) drives the rest.
interface score_tally_if #(
  parameter int unsigned NUM_LANES = 16
);
  logic [7:0]           keycode;
  logic [NUM_LANES-1:0] lane_hit;
  logic [13:0]          score;
  logic [15:0]          score_bcd;
  logic                 bcd_busy;
  logic [7:0]           hit_count;
  logic                 playing;
  logic                 game_over;

  modport master (
    output keycode, lane_hit,
    input  score, score_bcd, bcd_busy, hit_count, playing, game_over
  );

  modport slave (
    input  keycode, lane_hit,
    output score, score_bcd, bcd_busy, hit_count, playing, game_over
  );
endinterface

// File: rtl/score_tally.sv
// score_tally: collects the per-lane dropper hit flags, counts each lane's
// rising edge as one hit, accumulates a saturating score and hit count over
// a fixed-length song, and converts the score to 4-digit BCD with a
// sequential double-dabble engine (14 shift cycles per conversion).
// Ports:
//   frame_clk : sole clock, rising edge
//   Reset     : asynchronous active-low reset
//   bus       : score_tally_if slave (keycode, lane_hit in; score,
//               score_bcd, bcd_busy, hit_count, playing, game_over out)
module score_tally #(
  parameter int unsigned NUM_LANES   = 16,
  parameter int unsigned HIT_POINTS  = 10,
  parameter int unsigned SONG_FRAMES = 2400
) (
  input  logic           frame_clk,
  input  logic           Reset,
  score_tally_if.slave   bus
);

  localparam logic [7:0]  KEY_START  = 8'h2C;
  localparam logic [7:0]  KEY_RETURN = 8'h01;
  localparam logic [11:0] LAST_FRAME = 12'(SONG_FRAMES - 1);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;
  localparam int unsigned CNT_W      = $clog2(NUM_LANES + 1);
  localparam logic [3:0]  LAST_ITER  = 4'd13;

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} game_state_t;
  typedef enum logic       {C_IDLE, C_SHIFT}     conv_state_t;

  game_state_t          state_q, state_d;
  conv_state_t          cstate_q, cstate_d;

  logic [NUM_LANES-1:0] prev_hit_q;
  logic [13:0]          score_q;
  logic [7:0]           hit_cnt_q;
  logic [11:0]          frame_cnt_q;

  logic                 pending_q;
  logic [29:0]          shreg_q;
  logic [3:0]           iter_q;
  logic [15:0]          score_bcd_q;

  logic                 playing, game_over, bcd_busy;

  // ---------------------------------------------------------------------
  // Hit detection and accumulation
  // ---------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [NUM_LANES-1:0] new_hits;
  logic [CNT_W-1:0]     hits_n;
  logic [14:0]          score_sum;
  logic [8:0]           hit_sum;
  logic [13:0]          score_acc;
  logic [7:0]           hit_acc;
  logic                 start;
  logic                 conv_req;
  logic                 launch;

  always_comb begin
    new_hits  = bus.lane_hit & ~prev_hit_q;
    hits_n    = popcount(new_hits);
    // Max increment is NUM_LANES*99, so 15 bits cannot overflow from <=9999.
    score_sum = {1'b0, score_q} + 15'(hits_n) * 15'(HIT_POINTS);
    hit_sum   = {1'b0, hit_cnt_q} + 9'(hits_n);
    score_acc = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
    hit_acc   = (hit_sum > 9'd255) ? 8'd255 : hit_sum[7:0];
    start     = (state_q == IDLE) && (bus.keycode == KEY_START);
    conv_req  = start || ((state_q == PLAYING) && (score_acc != score_q));
    launch    = (cstate_q == C_IDLE) && pending_q;
  end

  // ---------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.keycode == KEY_START) state_d = PLAYING;
      PLAYING: begin
        // Abort takes priority over the end-of-song transition.
        if (bus.keycode == KEY_RETURN)     state_d = IDLE;
        else if (frame_cnt_q == LAST_FRAME) state_d = DONE;
      end
      DONE:    if (bus.keycode == KEY_RETURN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    playing   = (state_q == PLAYING);
    game_over = (state_q == DONE);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      prev_hit_q  <= '0;
      score_q     <= '0;
      hit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      prev_hit_q <= bus.lane_hit;
      if (start) begin
        score_q     <= '0;
        hit_cnt_q   <= '0;
        frame_cnt_q <= '0;
      end else if (state_q == PLAYING) begin
        score_q     <= score_acc;
        hit_cnt_q   <= hit_acc;
        frame_cnt_q <= frame_cnt_q + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Double-dabble BCD converter
  // ---------------------------------------------------------------------
  logic [29:0] adj;
  logic [29:0] shifted;

  always_comb begin
    adj = shreg_q;
    for (int unsigned d = 0; d < 4; d++) begin
      if (shreg_q[14 + 4*d +: 4] >= 4'd5)
        adj[14 + 4*d +: 4] = shreg_q[14 + 4*d +: 4] + 4'd3;
    end
    shifted = {adj[28:0], 1'b0};
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) cstate_q <= C_IDLE;
    else        cstate_q <= cstate_d;
  end

  always_comb begin
    cstate_d = cstate_q;
    case (cstate_q)
      C_IDLE:  if (pending_q)          cstate_d = C_SHIFT;
      C_SHIFT: if (iter_q == LAST_ITER) cstate_d = C_IDLE;
      default: cstate_d = C_IDLE;
    endcase
  end

  always_comb begin
    bcd_busy = (cstate_q == C_SHIFT);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      pending_q   <= 1'b0;
      shreg_q     <= '0;
      iter_q      <= '0;
      score_bcd_q <= '0;
    end else begin
      // A request on the launch edge wins over the clear, so a score change
      // that races the snapshot still triggers a follow-up conversion.
      pending_q <= conv_req | (pending_q & ~launch);
      if (launch) begin
        shreg_q <= {16'b0, score_q};
        iter_q  <= '0;
      end else if (cstate_q == C_SHIFT) begin
        shreg_q <= shifted;
        iter_q  <= iter_q + 4'd1;
        if (iter_q == LAST_ITER) score_bcd_q <= shifted[29:14];
      end
    end
  end

  assign bus.score     = score_q;
  assign bus.score_bcd = score_bcd_q;
  assign bus.bcd_busy  = bcd_busy;
  assign bus.hit_count = hit_cnt_q;
  assign bus.playing   = playing;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_score_tally.sv
module tb_score_tally;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  score_tally_if #(.NUM_LANES(16)) m_bus ();
  score_tally_if #(.NUM_LANES(16)) s_bus ();

  score_tally #(.NUM_LANES(16), .HIT_POINTS(10), .SONG_FRAMES(2400)) u_dut (
    .frame_clk (clk),
    .Reset     (rst_n),
    .bus       (m_bus.slave)
  );

  score_tally #(.NUM_LANES(16), .HIT_POINTS(10), .SONG_FRAMES(8)) u_short (
    .frame_clk (clk),
    .Reset     (rst_n),
    .bus       (s_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_score"}, 32'(m_bus.score), 32'd0);
    chk({tag, "_bcd"},   32'(m_bus.score_bcd), 32'd0);
    chk({tag, "_busy"},  32'(m_bus.bcd_busy), 32'd0);
    chk({tag, "_hits"},  32'(m_bus.hit_count), 32'd0);
    chk({tag, "_play"},  32'(m_bus.playing), 32'd0);
    chk({tag, "_over"},  32'(m_bus.game_over), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    m_bus.keycode = 8'h00; m_bus.lane_hit = '0;
    s_bus.keycode = 8'h00; s_bus.lane_hit = '0;

    // Reset state
    tick(2);
    chk_zero("rst");
    rst_n = 1'b1;
    tick(1);
    chk("idle_play", 32'(m_bus.playing), 32'd0);

    // Start, let the start-of-song conversion finish
    m_bus.keycode = 8'h2C;
    tick(1);
    m_bus.keycode = 8'h00;
    chk("start_play", 32'(m_bus.playing), 32'd1);
    chk("start_score", 32'(m_bus.score), 32'd0);
    tick(20);
    chk("start_bcd", 32'(m_bus.score_bcd), 32'h0000);
    chk("start_busy", 32'(m_bus.bcd_busy), 32'd0);

    // Single hit on lane 3; conversion timeline
    m_bus.lane_hit = 16'h0008;
    tick(1);
    m_bus.lane_hit = '0;
    chk("hit1_score", 32'(m_bus.score), 32'd10);
    chk("hit1_hits", 32'(m_bus.hit_count), 32'd1);
    chk("hit1_busy_k", 32'(m_bus.bcd_busy), 32'd0);
    tick(1);
    chk("hit1_busy_k1", 32'(m_bus.bcd_busy), 32'd1);
    tick(13);
    chk("hit1_busy_k14", 32'(m_bus.bcd_busy), 32'd1);
    chk("hit1_bcd_k14", 32'(m_bus.score_bcd), 32'h0000);
    tick(1);
    chk("hit1_bcd_k15", 32'(m_bus.score_bcd), 32'h0010);
    chk("hit1_busy_k15", 32'(m_bus.bcd_busy), 32'd0);

    // Lanes 0, 5, 15 together, then held high
    m_bus.lane_hit = 16'h8021;
    tick(1);
    chk("multi_score", 32'(m_bus.score), 32'd40);
    chk("multi_hits", 32'(m_bus.hit_count), 32'd4);
    tick(50);
    chk("hold_score", 32'(m_bus.score), 32'd40);
    chk("hold_hits", 32'(m_bus.hit_count), 32'd4);
    chk("hold_bcd", 32'(m_bus.score_bcd), 32'h0040);
    m_bus.lane_hit = '0;
    tick(1);

    // Second hit while converting: old snapshot completes, then relaunch
    m_bus.lane_hit = 16'h0002;
    tick(1);
    m_bus.lane_hit = '0;
    chk("busy_hit_a", 32'(m_bus.score), 32'd50);
    tick(1);
    chk("busy_launch", 32'(m_bus.bcd_busy), 32'd1);
    m_bus.lane_hit = 16'h0002;
    tick(1);
    m_bus.lane_hit = '0;
    chk("busy_hit_b", 32'(m_bus.score), 32'd60);
    tick(13);
    chk("old_snap_bcd", 32'(m_bus.score_bcd), 32'h0050);
    chk("old_snap_busy", 32'(m_bus.bcd_busy), 32'd0);
    tick(1);
    chk("relaunch_busy", 32'(m_bus.bcd_busy), 32'd1);
    tick(14);
    chk("relaunch_bcd", 32'(m_bus.score_bcd), 32'h0060);
    chk("relaunch_done", 32'(m_bus.bcd_busy), 32'd0);

    // Saturation: 16 hits per toggle
    for (int i = 0; i < 10; i++) begin
      m_bus.lane_hit = '1; tick(1);
      m_bus.lane_hit = '0; tick(1);
    end
    chk("bulk_score", 32'(m_bus.score), 32'd1660);
    chk("bulk_hits", 32'(m_bus.hit_count), 32'd166);
    for (int i = 0; i < 60; i++) begin
      m_bus.lane_hit = '1; tick(1);
      m_bus.lane_hit = '0; tick(1);
    end
    chk("sat_score", 32'(m_bus.score), 32'd9999);
    chk("sat_hits", 32'(m_bus.hit_count), 32'd255);
    m_bus.lane_hit = 16'h0001;
    tick(1);
    m_bus.lane_hit = '0;
    chk("sat_score2", 32'(m_bus.score), 32'd9999);
    chk("sat_hits2", 32'(m_bus.hit_count), 32'd255);
    tick(30);
    chk("sat_bcd", 32'(m_bus.score_bcd), 32'h9999);

    // Abort keeps totals
    m_bus.keycode = 8'h01;
    tick(1);
    m_bus.keycode = 8'h00;
    chk("abort_play", 32'(m_bus.playing), 32'd0);
    chk("abort_over", 32'(m_bus.game_over), 32'd0);
    chk("abort_score", 32'(m_bus.score), 32'd9999);

    // Short song (8 frames); hit on the final edge still counts
    s_bus.keycode = 8'h2C;
    tick(1);
    s_bus.keycode = 8'h00;
    chk("song_play", 32'(s_bus.playing), 32'd1);
    tick(7);
    chk("song_e7_play", 32'(s_bus.playing), 32'd1);
    chk("song_e7_over", 32'(s_bus.game_over), 32'd0);
    s_bus.lane_hit = 16'h0001;
    tick(1);
    s_bus.lane_hit = '0;
    chk("song_e8_over", 32'(s_bus.game_over), 32'd1);
    chk("song_e8_play", 32'(s_bus.playing), 32'd0);
    chk("song_last_hit", 32'(s_bus.score), 32'd10);
    tick(1);
    s_bus.lane_hit = 16'h0006;
    tick(1);
    s_bus.lane_hit = '0;
    chk("done_hit_score", 32'(s_bus.score), 32'd10);
    chk("done_hit_hits", 32'(s_bus.hit_count), 32'd1);
    s_bus.keycode = 8'h2C;
    tick(1);
    chk("done_2c_over", 32'(s_bus.game_over), 32'd1);
    s_bus.keycode = 8'h01;
    tick(1);
    s_bus.keycode = 8'h00;
    chk("ret_over", 32'(s_bus.game_over), 32'd0);
    chk("ret_play", 32'(s_bus.playing), 32'd0);
    chk("ret_score", 32'(s_bus.score), 32'd10);
    chk("ret_hits", 32'(s_bus.hit_count), 32'd1);
    tick(20);
    chk("ret_bcd", 32'(s_bus.score_bcd), 32'h0010);

    // Async reset mid-conversion with score=120
    m_bus.keycode = 8'h2C;
    tick(1);
    m_bus.keycode = 8'h00;
    chk("restart_score", 32'(m_bus.score), 32'd0);
    chk("restart_hits", 32'(m_bus.hit_count), 32'd0);
    tick(20);
    m_bus.lane_hit = 16'h0FFF;
    tick(1);
    m_bus.lane_hit = '0;
    chk("r120_score", 32'(m_bus.score), 32'd120);
    tick(4);
    chk("r120_busy", 32'(m_bus.bcd_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    tick(1);
    chk_zero("held");
    rst_n = 1'b1;
    tick(20);
    chk_zero("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_tally.md
# score_tally

Scoring stage directly downstream of the per-lane arrow droppers. It collects every dropper's `score` hit flag into a single `lane_hit` vector and detects each lane's rising edge as one hit. It accumulates points and a hit count over a fixed-length song, and converts the running score to 4-digit BCD with a sequential double-dabble engine for the hex/VGA score display. It follows the same keyboard start/return protocol as the droppers: 0x2C starts, 0x01 returns.

## Interface
- NUM_LANES, 16, number of dropper hit flags.
- HIT_POINTS, 10, points per hit (1..99).
- SONG_FRAMES, 2400, song length in frame_clk cycles (1..4095).
- frame_clk  in  1  sole clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- keycode  in  8  primary keyboard keycode.
- lane_hit  in  NUM_LANES  dropper score flags; level, held high after a hit.
- score  out  14  binary score, saturating at 9999.
- score_bcd  out  16  BCD of score; digit 3 in [15:12].
- bcd_busy  out  1  conversion in progress.
- hit_count  out  8  total hits, saturating at 255.
- playing  out  1  high in PLAYING.
- game_over  out  1  high in DONE.

## Operation
- Reset (Reset=0):
  - FSM goes to IDLE.
  - score, score_bcd, hit_count, frame counter, prev_hit and converter state are all cleared.
  - Every output is 0.
- FSM states: IDLE, PLAYING, DONE.
  - IDLE → PLAYING when keycode==0x2C. On that edge, score, hit_count and frame_cnt are cleared, and a BCD conversion is requested.
  - PLAYING → DONE on the edge where frame_cnt==SONG_FRAMES-1. Hits sampled on that edge still count.
  - PLAYING → IDLE when keycode==0x01 (abort). Totals are retained.
  - DONE → IDLE when keycode==0x01. Totals are retained.
  - 0x2C is ignored in PLAYING and DONE.
- frame_cnt (12 bits) increments each edge in PLAYING and holds otherwise.
- Hit detection:
  - prev_hit <= lane_hit on every edge, in all states.
  - new_hits = lane_hit & ~prev_hit.
  - n = popcount(new_hits), range 0..NUM_LANES. Multiple simultaneous lanes each count.
- Accumulation (PLAYING only):
  - score <= min(score + n*HIT_POINTS, 9999).
  - hit_count <= min(hit_count + n, 255).
  - Edges outside PLAYING never change totals.
- BCD converter (states C_IDLE, C_SHIFT):
  - Request: set whenever score is written with a different value, and on start.
  - Launch: in C_IDLE with a pending request, load shift register = {16'b0, score}, clear the pending flag and enter C_SHIFT.
  - Shifting: 14 iterations. Each iteration adds 3 to any BCD nibble ≥5, then shifts left by 1.
  - Completion: after the 14th shift, score_bcd <= BCD nibbles and the converter returns to C_IDLE.
  - A request arriving while in C_SHIFT sets pending. The running conversion completes with its old snapshot, then relaunches on the next edge.
  - bcd_busy = (state==C_SHIFT).

## Timing
- A lane_hit rising edge sampled at edge k updates score and hit_count at edge k. This is a 1-cycle latency from the input change.
- Conversion timeline:
  - Launch at edge k+1.
  - Shifts at edges k+2..k+15.
  - score_bcd valid at edge k+15.
  - bcd_busy high from k+1 to k+15.
- Worst case, score_bcd matches score no more than 30 edges after the last score change.
- playing and game_over are registered FSM decodes; they change on the transition edge.
- Asynchronous reset takes effect mid-conversion or mid-song with no completion.
- The first edge after reset release starts in IDLE, with prev_hit = 0.

## Test plan
- Reset, then 0x2C, then lane 3 rising for 1 cycle → next edge: score=10, hit_count=1; after 15 more edges score_bcd=0x0010.
- Lanes 0, 5 and 15 rise on the same edge → score +30, hit_count +3. Holding the lanes high for 50 cycles adds nothing further.
- Hits 1 cycle apart while bcd_busy → score_bcd ends at the final score (e.g. 0x0020), with one relaunch observed.
- Preload near the limit with 1000 hits, then hit again → score=9999, score_bcd=0x9999, hit_count=255.
- SONG_FRAMES=8: start, wait 8 edges → game_over=1, playing=0. Hits during DONE are ignored. 0x2C in DONE is ignored. 0x01 → IDLE with totals kept.
- Drive Reset=0 asynchronously mid-conversion with score=120 → all outputs 0 immediately, FSM in IDLE.
